// File: rtl/ofm_stream_buffer.sv
// ofm_stream_buffer: captures per-pixel output vectors into RAM and replays them as a serial ifm stream (optional RD_REPLAY_EN adds rd_rewind and endless re-reads)
module ofm_stream_buffer #(
    parameter int WIDTH  = 16,
    parameter int CH     = 368,
    parameter int PIXELS = 64,
    parameter int GAP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ofm_in [CH],
    input  logic             ofm_sample,
    output logic             ram_feedback,
    input  logic             rd_en,
`ifdef RD_REPLAY_EN
    input  logic             rd_rewind,
`endif
    output logic [WIDTH-1:0] ifm_out,
    output logic             buf_full,
    output logic             rd_done,
    output logic             ovf_err
);
    localparam int DEPTH = PIXELS * CH;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = CH > 1 ? $clog2(CH) : 1;
    localparam int QW = CH + GAP > 1 ? $clog2(CH + GAP) : 1;
    localparam int XW = PIXELS > 1 ? $clog2(PIXELS) : 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(CH - 1);
    localparam logic [QW-1:0] POS_LAST = QW'(CH + GAP - 1);
    localparam logic [XW-1:0] PIX_LAST = XW'(PIXELS - 1);

    typedef enum logic [1:0] {FILL, DRAIN, FULL, READ} state_t;

    logic rewind;
`ifdef RD_REPLAY_EN
    localparam state_t END_ST = FULL;
    localparam logic   KEEP_FULL = 1'b1;
    assign rewind = rd_rewind;
`else
    localparam state_t END_ST = FILL;
    localparam logic   KEEP_FULL = 1'b0;
    assign rewind = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_wr_q, ch_wr_d;
    logic [XW-1:0]   pix_wr_q, pix_wr_d, pix_rd_q, pix_rd_d;
    logic [QW-1:0]   pos_rd_q, pos_rd_d;
    logic            buf_full_q, buf_full_d, fb_q, fb_d, done_q, done_d;
    logic            ovf_q, ovf_d, show_q, show_d, gap_q, gap_d;
    logic            wr_en, rd_issue, in_ch, pos_last, pix_last;
    logic [AW-1:0]   wr_addr, rd_addr;
    logic [WIDTH-1:0] shadow [CH];
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    assign in_ch    = {1'b0, pos_rd_q} < (QW + 1)'(CH);
    assign pos_last = pos_rd_q == POS_LAST;
    assign pix_last = pix_rd_q == PIX_LAST;
    assign wr_addr  = AW'(pix_wr_q) * AW'(CH) + AW'(ch_wr_q);
    assign rd_addr  = AW'(pix_rd_q) * AW'(CH) + AW'(pos_rd_q);

    // Next-state logic: fill/drain sequencing on the write side, stream counters on the read side
    always_comb begin
        state_d    = state_q;
        ch_wr_d    = ch_wr_q;
        pix_wr_d   = pix_wr_q;
        pix_rd_d   = pix_rd_q;
        pos_rd_d   = pos_rd_q;
        buf_full_d = buf_full_q;
        fb_d       = 1'b0;
        done_d     = 1'b0;
        ovf_d      = ovf_q | (state_q == DRAIN && ofm_sample);
        show_d     = show_q;
        gap_d      = gap_q;
        wr_en      = 1'b0;
        rd_issue   = 1'b0;
        case (state_q)
            FILL: begin
                show_d = 1'b0;
                if (ofm_sample) begin
                    state_d = DRAIN;
                    ch_wr_d = '0;
                end
            end
            DRAIN: begin
                show_d  = 1'b0;
                wr_en   = 1'b1;
                ch_wr_d = ch_wr_q == CH_LAST ? '0 : ch_wr_q + 1'b1;
                if (ch_wr_q == CH_LAST) begin
                    pix_wr_d   = pix_wr_q == PIX_LAST ? '0 : pix_wr_q + 1'b1;
                    state_d    = pix_wr_q == PIX_LAST ? FULL : FILL;
                    buf_full_d = pix_wr_q == PIX_LAST;
                    fb_d       = pix_wr_q == PIX_LAST;
                end
            end
            default: begin
                if (rewind) begin
                    pix_rd_d = '0;
                    pos_rd_d = '0;
                    state_d  = FULL;
                end else if (rd_en) begin
                    rd_issue = 1'b1;
                    show_d   = 1'b1;
                    gap_d    = !in_ch;
                    state_d  = READ;
                    pos_rd_d = pos_last ? '0 : pos_rd_q + 1'b1;
                    pix_rd_d = !pos_last ? pix_rd_q : pix_last ? '0 : pix_rd_q + 1'b1;
                    if (pos_last && pix_last) begin
                        done_d     = 1'b1;
                        pix_wr_d   = '0;
                        state_d    = END_ST;
                        buf_full_d = KEEP_FULL;
                    end
                end
            end
        endcase
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FILL;
            ch_wr_q    <= '0;
            pix_wr_q   <= '0;
            pix_rd_q   <= '0;
            pos_rd_q   <= '0;
            buf_full_q <= 1'b0;
            fb_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            show_q     <= 1'b0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_wr_q    <= ch_wr_d;
            pix_wr_q   <= pix_wr_d;
            pix_rd_q   <= pix_rd_d;
            pos_rd_q   <= pos_rd_d;
            buf_full_q <= buf_full_d;
            fb_q       <= fb_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            show_q     <= show_d;
            gap_q      <= gap_d;
        end
    end

    // Shadow bank latches the whole vector so the producer may change ofm_in during the drain
    always_ff @(posedge clk) begin
        if (state_q == FILL && ofm_sample) shadow <= ofm_in;
    end

    // Single-port RAM; write and read never coincide since they belong to exclusive states
    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= shadow[ch_wr_q];
        if (rd_issue && in_ch) rdata_q <= ram[rd_addr];
    end

    assign ifm_out      = show_q && !gap_q ? rdata_q : '0;
    assign buf_full     = buf_full_q;
    assign ram_feedback = fb_q;
    assign rd_done      = done_q;
    assign ovf_err      = ovf_q;
endmodule

// File: tb/tb_ofm_stream_buffer.sv
// tb_ofm_stream_buffer: directed-random check of ofm_stream_buffer against a queue-based stream model
module tb_ofm_stream_buffer;
    localparam int W = 16, CH = 4, PX = 2, GAP = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  ofm_in [CH];
    logic          ofm_sample = 1'b0;
    logic          rd_en = 1'b0;
    logic          ram_feedback, buf_full, rd_done, ovf_err;
    logic [W-1:0]  ifm_out;
`ifdef RD_REPLAY_EN
    logic          rd_rewind = 1'b0;
    localparam bit REPLAY = 1'b1;
`else
    localparam bit REPLAY = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [W-1:0] mdl [PX][CH];

    ofm_stream_buffer #(.WIDTH(W), .CH(CH), .PIXELS(PX), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .ofm_in(ofm_in), .ofm_sample(ofm_sample),
        .ram_feedback(ram_feedback), .rd_en(rd_en),
`ifdef RD_REPLAY_EN
        .rd_rewind(rd_rewind),
`endif
        .ifm_out(ifm_out), .buf_full(buf_full), .rd_done(rd_done), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #2;
        check("rst_fb", 32'(ram_feedback), 0);
        check("rst_ifm", 32'(ifm_out), 0);
        check("rst_full", 32'(buf_full), 0);
        check("rst_done", 32'(rd_done), 0);
        check("rst_ovf", 32'(ovf_err), 0);
        rst = 1'b1;
        step();
    endtask

    task automatic fill_pixel(input int p);
        for (int c = 0; c < CH; c++) ofm_in[c] = mdl[p][c];
        ofm_sample = 1'b1;
        step();
        ofm_sample = 1'b0;
        for (int i = 0; i < CH; i++) begin
            check("fb_early", 32'(ram_feedback), 0);
            step();
        end
        check("feedback", 32'(ram_feedback), 32'(p == PX - 1));
        check("full_after_fill", 32'(buf_full), 32'(p == PX - 1));
        if (p == PX - 1) begin
            step();
            check("fb_pulse_len", 32'(ram_feedback), 0);
        end
    endtask

    // mode 0: rd_en held high, 1: random rd_en, 2: repeating 1,0,0,1 stall pattern
    task automatic read_stream(input int mode);
        logic [W-1:0] exp_q [$];
        logic [W-1:0] cur = '0;
        int n = (CH + GAP) * PX;
        int issued = 0;
        int k = 0;
        for (int p = 0; p < PX; p++) begin
            for (int c = 0; c < CH; c++) exp_q.push_back(mdl[p][c]);
            for (int g = 0; g < GAP; g++) exp_q.push_back('0);
        end
        while (issued < n && k < 400) begin
            rd_en = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (k % 4 == 1 || k % 4 == 2) ? 1'b0 : 1'b1;
            step();
            if (rd_en) begin
                cur = exp_q.pop_front();
                issued++;
            end
            check("ifm", 32'(ifm_out), 32'(cur));
            check("rd_done", 32'(rd_done), 32'(rd_en && issued == n));
            check("buf_full_rd", 32'(buf_full), 32'(REPLAY || issued < n));
            k++;
        end
        check("rd_timeout", issued, n);
        rd_en = 1'b0;
        step();
        check("ifm_after", 32'(ifm_out), 0);
        check("done_len", 32'(rd_done), 0);
    endtask

    task automatic randomize_map();
        for (int p = 0; p < PX; p++)
            for (int c = 0; c < CH; c++) mdl[p][c] = W'($urandom);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) ofm_in[c] = '0;
        do_reset();

        // rd_en while filling is ignored
        rd_en = 1'b1;
        repeat (3) begin
            step();
            check("ifm_fill_ign", 32'(ifm_out), 0);
            check("full_fill_ign", 32'(buf_full), 0);
        end
        rd_en = 1'b0;

        // fill with 16*p+c, samples in FULL ignored, then full-speed readback
        for (int p = 0; p < PX; p++)
            for (int c = 0; c < CH; c++) mdl[p][c] = W'(16 * p + c);
        for (int p = 0; p < PX; p++) fill_pixel(p);
        check("ifm_full_idle", 32'(ifm_out), 0);
        for (int c = 0; c < CH; c++) ofm_in[c] = 16'hdead;
        ofm_sample = 1'b1;
        step();
        step();
        ofm_sample = 1'b0;
        check("ovf_in_full", 32'(ovf_err), 0);
        check("full_hold", 32'(buf_full), 1);
        read_stream(0);
        check("full_cleared", 32'(buf_full), 32'(REPLAY));

`ifdef RD_REPLAY_EN
        rd_en = 1'b1;
        repeat (CH + GAP + 2) step();
        rd_en = 1'b0;
        rd_rewind = 1'b1;
        step();
        rd_rewind = 1'b0;
        check("rewind_full", 32'(buf_full), 1);
        read_stream(0);
`endif

        // overflow: second sample two cycles into the drain is dropped
        do_reset();
        randomize_map();
        for (int c = 0; c < CH; c++) ofm_in[c] = mdl[0][c];
        ofm_sample = 1'b1;
        step();
        ofm_sample = 1'b0;
        step();
        for (int c = 0; c < CH; c++) ofm_in[c] = ~mdl[0][c];
        ofm_sample = 1'b1;
        step();
        ofm_sample = 1'b0;
        check("ovf_set", 32'(ovf_err), 1);
        step();
        step();
        check("fb_ovf_pix0", 32'(ram_feedback), 0);
        fill_pixel(1);
        check("ovf_sticky", 32'(ovf_err), 1);
        read_stream(2);
        check("ovf_sticky_end", 32'(ovf_err), 1);

        // reset in the middle of a drain, then a clean fill with random stalls on read
        do_reset();
        randomize_map();
        for (int c = 0; c < CH; c++) ofm_in[c] = W'($urandom);
        ofm_sample = 1'b1;
        step();
        ofm_sample = 1'b0;
        step();
        step();
        do_reset();
        for (int p = 0; p < PX; p++) fill_pixel(p);
        read_stream(1);
        check("ovf_clean", 32'(ovf_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
